// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the boot-time program loader.
// master drives bytes, slave (the loader) returns byte_ready.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream, writes them to
// instruction memory, and holds the fetch pipeline until the checksum verifies.
module imem_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          R,
  input  logic          start,
  imem_loader_if.slave  bs,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, CSUM, DONE, ERR
  } state_e;

  state_e        st_q, st_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   sh_q, sh_d;
  logic [AW:0]   n_q, n_d;
  logic [31:0]   sum_q, sum_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   wl_q, wl_d;

  logic          take;
  logic          last;
  logic [31:0]   word;
  logic [AW:0]   wl_inc;

  assign bs.byte_ready = (st_q == HDR) ||
                         (st_q == DATA) ||
                         (st_q == CSUM);

  assign take   = bs.byte_valid && bs.byte_ready;
  assign last   = take && (cnt_q == 2'd3);
  assign word   = {sh_q, bs.byte_in};
  assign wl_inc = wl_q + 1'b1;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    n_d     = n_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wl_d    = wl_q;
    if (take) begin
      cnt_d = cnt_q + 2'd1;
      sh_d  = {sh_q[15:0], bs.byte_in};
    end
    unique case (st_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          st_d  = HDR;
          cnt_d = 2'd0;
          sum_d = 32'd0;
          wl_d  = '0;
        end
      end
      HDR: begin
        if (last) begin
          // full 32-bit compare: high header bits must not alias a short length
          if (word == 32'd0 || word > 32'(DEPTH)) begin
            st_d = ERR;
          end else begin
            n_d  = word[AW:0];
            st_d = DATA;
          end
        end
      end
      DATA: begin
        if (last) begin
          we_d    = 1'b1;
          waddr_d = wl_q[AW-1:0];
          wdata_d = word;
          sum_d   = sum_q + word;
          wl_d    = wl_inc;
          if (wl_inc == n_q) st_d = CSUM;
        end
      end
      CSUM: begin
        if (last) st_d = (word == sum_q) ? DONE : ERR;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      st_q    <= IDLE;
      cnt_q   <= 2'd0;
      sh_q    <= '0;
      n_q     <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wl_q    <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      n_q     <= n_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wl_q    <= wl_d;
    end
  end

  assign mem_we       = we_q;
  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign words_loaded = wl_q;
  assign load_done    = (st_q == DONE);
  assign load_err     = (st_q == ERR);
  assign cpu_hold     = (st_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-load scenarios plus
// hand-written reset, idle-byte, restart and abort sequences.
module tb_imem_loader;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          R = 1'b1;
  logic          start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   words_loaded;

  imem_loader_if bs ();

  imem_loader #(.DEPTH(128), .AW(AW)) dut (
    .clk          (clk),
    .R            (R),
    .start        (start),
    .bs           (bs),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               nsend;
    logic [0:3][31:0] w;
    bit               stall;
    bit               edone;
    bit               eerr;
    int               ewl;
    int               enwr;
  } vec_t;

  vec_t tbl [7];

  int nvec = 0;
  int nerr = 0;

  logic [AW+31:0] wq [$];
  logic           we_prev = 1'b0;
  logic           b2b = 1'b0;

  always @(negedge clk) begin
    if (mem_we) wq.push_back({mem_waddr, mem_wdata});
    if (mem_we && we_prev) b2b <= 1'b1;
    we_prev <= mem_we;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, bit stall);
    int t;
    t = 0;
    bs.byte_in    = b;
    bs.byte_valid = 1'b1;
    while (!bs.byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bs.byte_ready) begin
      nvec++;
      nerr++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    @(negedge clk);
    bs.byte_valid = 1'b0;
    if (stall) @(negedge clk);
  endtask

  task automatic send_word(logic [31:0] w, bit stall);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], stall);
  endtask

  task automatic run_vec(int k);
    int base;
    base = wq.size();
    pulse_start();
    for (int i = 0; i < tbl[k].nsend; i++)
      send_word(tbl[k].w[i], tbl[k].stall);
    chk($sformatf("v%0d_done", k), 32'(load_done), 32'(tbl[k].edone));
    chk($sformatf("v%0d_err", k), 32'(load_err), 32'(tbl[k].eerr));
    chk($sformatf("v%0d_hold", k), 32'(cpu_hold), 32'(!tbl[k].edone));
    chk($sformatf("v%0d_wl", k), 32'(words_loaded), 32'(tbl[k].ewl));
    chk($sformatf("v%0d_rdy", k), 32'(bs.byte_ready), 32'd0);
    chk($sformatf("v%0d_nwr", k), 32'(wq.size() - base), 32'(tbl[k].enwr));
    for (int j = 0; j < tbl[k].enwr && base + j < wq.size(); j++) begin
      chk($sformatf("v%0d_addr%0d", k, j),
          32'(wq[base+j][AW+31:32]), 32'(j));
      chk($sformatf("v%0d_data%0d", k, j),
          wq[base+j][31:0], tbl[k].w[j+1]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    tbl[0] = '{4, {32'h00000002, 32'h82100001, 32'h84100002, 32'h06200003},
               1'b0, 1'b1, 1'b0, 2, 2};
    tbl[1] = '{4, {32'h00000002, 32'h82100001, 32'h84100002, 32'h06200004},
               1'b0, 1'b0, 1'b1, 2, 2};
    tbl[2] = '{1, {32'h00000000, 32'h0, 32'h0, 32'h0},
               1'b0, 1'b0, 1'b1, 0, 0};
    tbl[3] = '{1, {32'h00000081, 32'h0, 32'h0, 32'h0},
               1'b0, 1'b0, 1'b1, 0, 0};
    tbl[4] = '{1, {32'h01000001, 32'h0, 32'h0, 32'h0},
               1'b0, 1'b0, 1'b1, 0, 0};
    tbl[5] = '{4, {32'h00000002, 32'h82100001, 32'h84100002, 32'h06200003},
               1'b1, 1'b1, 1'b0, 2, 2};
    tbl[6] = '{4, {32'h00000002, 32'hFFFFFFFF, 32'h00000002, 32'h00000001},
               1'b0, 1'b1, 1'b0, 2, 2};

    bs.byte_in    = 8'h00;
    bs.byte_valid = 1'b0;
    R = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_rdy", 32'(bs.byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_wl", 32'(words_loaded), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    R = 1'b0;

    // a byte offered in IDLE must not be consumed
    bs.byte_in    = 8'hEE;
    bs.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy", 32'(bs.byte_ready), 32'd0);
    bs.byte_valid = 1'b0;
    base = wq.size();
    pulse_start();
    chk("hdr_hold", 32'(cpu_hold), 32'd1);
    chk("hdr_rdy", 32'(bs.byte_ready), 32'd1);
    send_word(32'h00000001, 1'b0);
    send_word(32'h12345678, 1'b0);
    send_word(32'h12345678, 1'b0);
    chk("idle_done", 32'(load_done), 32'd1);
    chk("idle_nwr", 32'(wq.size() - base), 32'd1);
    if (wq.size() > base) chk("idle_data", wq[base][31:0], 32'h12345678);

    for (int k = 0; k < 7; k++) run_vec(k);

    // restart from DONE
    run_vec(0);
    base = wq.size();
    pulse_start();
    chk("rs_hold", 32'(cpu_hold), 32'd1);
    chk("rs_done", 32'(load_done), 32'd0);
    chk("rs_wl", 32'(words_loaded), 32'd0);
    send_word(32'h00000001, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    send_word(32'hA5A5A5A5, 1'b0);
    chk("rs_done2", 32'(load_done), 32'd1);
    chk("rs_wl2", 32'(words_loaded), 32'd1);
    chk("rs_nwr", 32'(wq.size() - base), 32'd1);
    if (wq.size() > base) begin
      chk("rs_addr", 32'(wq[base][AW+31:32]), 32'd0);
      chk("rs_data", wq[base][31:0], 32'hA5A5A5A5);
    end

    // abort after five DATA-phase bytes
    base = wq.size();
    pulse_start();
    send_word(32'h00000002, 1'b0);
    send_word(32'h82100001, 1'b0);
    send_byte(8'h84, 1'b0);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    chk("ab_rdy", 32'(bs.byte_ready), 32'd0);
    chk("ab_hold", 32'(cpu_hold), 32'd1);
    chk("ab_wl", 32'(words_loaded), 32'd0);
    chk("ab_err", 32'(load_err), 32'd0);
    bs.byte_in    = 8'h10;
    bs.byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    bs.byte_valid = 1'b0;
    chk("ab_nwr", 32'(wq.size() - base), 32'd1);
    chk("ab_we", 32'(mem_we), 32'd0);

    chk("no_b2b", 32'(b2b), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
